// File: rtl/seq_frame_tx_pkg.sv
// Shared definitions for the framed serial transmitter: state encoding,
// sync pattern and fixed section lengths.
package seq_frame_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0]  SYNC_PAT = 4'b1101;
    localparam int unsigned SYNC_LEN = 4;
    localparam int unsigned GAP_LEN  = 2;

    // Sync bit k (0 = first on the line); ~k maps 0..3 onto pattern bits 3..0.
    function automatic logic sync_bit(input logic [1:0] k);
        return SYNC_PAT[~k];
    endfunction

endpackage

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1101 sync, MSB-first payload with a 0 stuffed
// after every 110 seen on the line, then a two-bit zero gap.
module seq_frame_tx
    import seq_frame_tx_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              dout,
    output logic              frame_done
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t            state, state_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [CNT_W-1:0]  bcnt, bcnt_n;
    logic [1:0]        scnt, scnt_n;
    logic [1:0]        gcnt, gcnt_n;
    logic [2:0]        hist;
    logic              dout_n;
    logic              done_n;

    assign tx_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GAP;
            data_q     <= '0;
            bcnt       <= '0;
            scnt       <= '0;
            gcnt       <= '0;
            hist       <= '0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            bcnt       <= bcnt_n;
            scnt       <= scnt_n;
            gcnt       <= gcnt_n;
            hist       <= {hist[1:0], dout_n};
            dout       <= dout_n;
            frame_done <= done_n;
        end
    end

    // Everything here selects the bit that goes on the line at the next edge;
    // the payload is shifted left so its MSB is always the next payload bit.
    always_comb begin
        state_n = state;
        data_n  = data_q;
        bcnt_n  = bcnt;
        scnt_n  = scnt;
        gcnt_n  = gcnt;
        dout_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_n = SYNC;
                    data_n  = tx_data;
                    bcnt_n  = '0;
                    scnt_n  = '0;
                    dout_n  = sync_bit(2'd0);
                end
            end
            SYNC: begin
                if (scnt == 2'(SYNC_LEN - 1)) begin
                    // Line history ends in 101 here, so the first payload bit never needs a stuff.
                    state_n = DATA;
                    dout_n  = data_q[DATA_W-1];
                    data_n  = data_q << 1;
                    bcnt_n  = CNT_W'(1);
                    done_n  = (DATA_W == 1);
                end else begin
                    scnt_n = scnt + 2'd1;
                    dout_n = sync_bit(scnt + 2'd1);
                end
            end
            DATA: begin
                if (bcnt == CNT_W'(DATA_W)) begin
                    state_n = GAP;
                    gcnt_n  = '0;
                end else if (hist != 3'b110) begin
                    dout_n = data_q[DATA_W-1];
                    data_n = data_q << 1;
                    bcnt_n = bcnt + 1'b1;
                    done_n = (bcnt == CNT_W'(DATA_W - 1));
                end
            end
            GAP: begin
                if (gcnt == 2'(GAP_LEN - 1)) begin
                    state_n = IDLE;
                end else begin
                    gcnt_n = gcnt + 2'd1;
                end
            end
            default: state_n = GAP;
        endcase
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: expected line streams are built from
// the framing rules and compared bit by bit, with a 1101 monitor on dout.
module tb_seq_frame_tx;

    localparam int MODE_QUIET    = 0;
    localparam int MODE_SCRAMBLE = 1;
    localparam int MODE_HOLD     = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       dout;
    logic       frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int det_cnt  = 0;
    logic [2:0] win = '0;

    bit exp_q[$];
    int done_idx;

    seq_frame_tx #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .dout       (dout),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // 1101 monitor over the line as seen at each falling edge.
    always @(negedge clk) begin
        if ({win, dout} == 4'b1101) det_cnt++;
        win <= {win[1:0], dout};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line bits from acceptance to the end of the gap.
    function automatic void build_frame(input logic [7:0] d);
        logic [3:0] pat = 4'b1101;
        int sent = 0;
        int n;
        exp_q = {};
        for (int i = 3; i >= 0; i--) exp_q.push_back(pat[i]);
        while (sent < 8) begin
            n = exp_q.size();
            if (exp_q[n-3] && exp_q[n-2] && !exp_q[n-1]) begin
                exp_q.push_back(1'b0);
            end else begin
                exp_q.push_back(d[7-sent]);
                sent++;
            end
        end
        done_idx = exp_q.size() - 1;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endfunction

    // Entered at a falling edge with the DUT idle; leaves at the falling edge
    // where tx_ready is back.
    task automatic run_frame(input logic [7:0] d, input int mode);
        int snap = det_cnt;
        build_frame(d);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_eq("dout", 32'(dout), 32'(exp_q[i]));
            check_eq("frame_done", 32'(frame_done), 32'(i == done_idx));
            check_eq("ready_busy", 32'(tx_ready), 32'd0);
            if (mode == MODE_SCRAMBLE) begin
                tx_data  = 8'($urandom);
                tx_valid = 1'($urandom);
            end else if (mode == MODE_QUIET) begin
                tx_valid = 1'b0;
            end
            if (i == exp_q.size() - 1 && mode != MODE_HOLD) tx_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("ready_back", 32'(tx_ready), 32'd1);
        check_eq("idle_dout", 32'(dout), 32'd0);
        check_eq("detections", 32'(det_cnt - snap), 32'd1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        #1;
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_ready", 32'(tx_ready), 32'd0);
        check_eq("rst_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold_dout", 32'(dout), 32'd0);
        check_eq("rst_hold_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("post_rst_ready", 32'(tx_ready), 32'd0);
            check_eq("post_rst_dout", 32'(dout), 32'd0);
        end
        @(negedge clk);
        check_eq("post_rst_idle", 32'(tx_ready), 32'd1);
        check_eq("post_rst_idle_dout", 32'(dout), 32'd0);
    endtask

    initial begin
        int snap;
        #2;
        do_reset();

        run_frame(8'hA5, MODE_QUIET);
        run_frame(8'hDD, MODE_QUIET);

        snap = det_cnt;
        run_frame(8'hFF, MODE_HOLD);
        run_frame(8'h00, MODE_HOLD);
        tx_valid = 1'b0;
        check_eq("b2b_detections", 32'(det_cnt - snap), 32'd2);

        run_frame(8'h6C, MODE_SCRAMBLE);

        // Abandon an 8'hDD frame part-way through its payload.
        build_frame(8'hDD);
        tx_data  = 8'hDD;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_valid = 1'b0;
            check_eq("trunc_dout", 32'(dout), 32'(exp_q[i]));
            check_eq("trunc_done", 32'(frame_done), 32'd0);
        end
        #2;
        do_reset();
        run_frame(8'hA5, MODE_QUIET);

        for (int k = 0; k < 30; k++) begin
            int idle = $urandom_range(0, 3);
            for (int j = 0; j < idle; j++) begin
                @(negedge clk);
                check_eq("idle_ready", 32'(tx_ready), 32'd1);
                check_eq("idle_line", 32'(dout), 32'd0);
            end
            run_frame(8'($urandom), $urandom_range(0, 1) == 0 ? MODE_QUIET : MODE_SCRAMBLE);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter: DATA_W, default 8, payload bits per frame (legal range 1..32).
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: tx_data  input  DATA_W  payload word, sampled only on acceptance.
REQ-005 Port: tx_valid  input  1  payload offered.
REQ-006 Port: tx_ready  output  1  block can accept a payload this cycle.
REQ-007 Port: dout  output  1  registered serial line, one bit per clock.
REQ-008 Port: frame_done  output  1  one-cycle pulse, high in the cycle dout carries the last payload bit.

Function
REQ-009 The FSM SHALL have states IDLE, SYNC, DATA and GAP.
REQ-010 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_ready SHALL equal (state==IDLE), registered-state-derived, with no combinational path from tx_valid.
REQ-011 On the accepting edge, the block SHALL latch tx_data, enter SYNC and load dout=1; later tx_data changes SHALL be ignored until the next acceptance.
REQ-012 SYNC SHALL drive the pattern 1,1,0,1 on dout over 4 consecutive cycles, with no stuffing, then enter DATA.
REQ-013 DATA SHALL send the latched payload MSB first, one bit per cycle.
REQ-014 A 3-bit history register SHALL track the last three dout bits; it SHALL be cleared on reset and updated on every edge.
REQ-015 In DATA, when history==3'b110, the block SHALL drive a stuff bit 0 without consuming a payload bit, regardless of the next payload value.
REQ-016 The payload bit counter SHALL count payload bits only; DATA SHALL exit after DATA_W payload bits, with stuffed-bit count unbounded by the counter width.
REQ-017 After the last payload bit, GAP SHALL drive 0 for exactly 2 cycles, then enter IDLE.
REQ-018 IDLE SHALL drive dout=0, and tx_valid while tx_ready=0 SHALL be ignored, with no queuing.
REQ-019 Frame length from the accepting edge to tx_ready re-assertion SHALL be 4 + DATA_W + stuff_count + 2 cycles.
REQ-020 The earliest back-to-back acceptance SHALL be in the first IDLE cycle, guaranteeing at least 3 zeros between frames.
REQ-021 A 1101 detector on dout SHALL fire exactly once per frame, on the 4th sync bit.

Reset
REQ-022 rst_n low SHALL immediately force: dout=0, tx_ready=0, frame_done=0, history=000, counters=0, and state=GAP with gap count 0.
REQ-023 After rst_n deasserts, 2 zero cycles (GAP) SHALL precede IDLE, so a frame truncated by reset cannot combine with the next sync into a false match.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no resumption and no frame_done pulse.

Structure
REQ-025 A shared package SHALL hold the state encoding (2 bits), SYNC_PAT=4'b1101, SYNC_LEN=4 and GAP_LEN=2.
REQ-026 There SHALL be no sub-module; the stuffing decision and history register are inline, and the bench MAY instance a 1101 Mealy detector as monitor.

Verification
REQ-027 Reset release: 2 cycles dout=0 and tx_ready=0, then tx_ready=1 and dout=0.
REQ-028 tx_data=8'hA5: dout = 1101 1 0 [0] 1 0 0 1 0 1 then 00; 1 stuff; 15 cycles; frame_done on the 13th bit; monitor fires once.
REQ-029 tx_data=8'hDD: payload stream 1 1 0 [0] 1 1 1 0 [0] 1; 2 stuffs; 16 cycles; monitor fires once.
REQ-030 tx_data=8'hFF then 8'h00 with tx_valid held high: no stuffing, 14-cycle frames, second acceptance in the first IDLE cycle, 3 zeros between frames, exactly 2 detections.
REQ-031 rst_n pulsed low mid-DATA for 8'hDD: dout=0 immediately, no frame_done, tx_ready=1 after 2 cycles; the next frame 8'hA5 matches REQ-028 exactly.
REQ-032 tx_data changed and tx_valid toggled during an active frame: the serialized stream is unchanged and no extra acceptance occurs.
